// File: rtl/bsg_idiv_iterative_restoring_pkg.sv
// Package bsg_idiv_pkg: shared types and helpers for the iterative restoring
// divider.
//   idiv_state_e   : divider FSM states (idle, calculate, adjust signs, done)
//   idiv_cnt_width : width of the step counter for a given operand width
package bsg_idiv_pkg;

    typedef enum logic [1:0] {
        eIDLE = 2'd0,
        eCALC = 2'd1,
        eADJ  = 2'd2,
        eDONE = 2'd3
    } idiv_state_e;

    // The counter runs width-1 down to 0, so clog2(width) bits are enough.
    function automatic int idiv_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bsg_idiv_iterative_restoring_if.sv
// Request/response bundle of the iterative divider.
//   master : requester side (drives request fields and yumi_i)
//   slave  : divider side (drives ready_o, v_o, result_o)
// Signals keep the divider's port names so the bundle reads like the
// multiplier's port list: v_i/ready_o request handshake, opA_i/opB_i
// operands, signed_opA_i/signed_opB_i per-operand signedness,
// gets_remainder_i result select, v_o/yumi_i result handshake, result_o.
interface bsg_idiv_iterative_restoring_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] opA_i;
    logic [width_p-1:0] opB_i;
    logic               signed_opA_i;
    logic               signed_opB_i;
    logic               gets_remainder_i;
    logic               v_o;
    logic [width_p-1:0] result_o;
    logic               yumi_i;

    modport master (
        output v_i, opA_i, opB_i, signed_opA_i, signed_opB_i,
               gets_remainder_i, yumi_i,
        input  ready_o, v_o, result_o
    );

    modport slave (
        input  v_i, opA_i, opB_i, signed_opA_i, signed_opB_i,
               gets_remainder_i, yumi_i,
        output ready_o, v_o, result_o
    );
endinterface

// File: rtl/bsg_idiv_iterative_restoring_restore_step.sv
// bsg_idiv_restore_step: one combinational restoring-division step.
//   rem          : current partial remainder (always < divisor)
//   dividend_msb : dividend bit shifted into the remainder this step
//   divisor      : unsigned divisor
//   rem_next     : partial remainder after the step
//   quot_bit     : quotient bit produced by the step
module bsg_idiv_restore_step #(
    parameter int width_p = 32
) (
    input  logic [width_p-1:0] rem,
    input  logic               dividend_msb,
    input  logic [width_p-1:0] divisor,
    output logic [width_p-1:0] rem_next,
    output logic               quot_bit
);
    logic [width_p:0] shifted_s;
    logic [width_p:0] trial_s;

    // Because rem < divisor, the shifted value is < 2*divisor, so a width_p+1
    // bit difference is wide enough: its MSB is set exactly when it underflows.
    assign shifted_s = {rem, dividend_msb};
    assign trial_s   = shifted_s - {1'b0, divisor};
    assign quot_bit  = ~trial_s[width_p];
    assign rem_next  = quot_bit ? trial_s[width_p-1:0] : shifted_s[width_p-1:0];
endmodule

// File: rtl/bsg_idiv_iterative_restoring.sv
// bsg_idiv_iterative_restoring: iterative restoring integer divider, one
// quotient bit per cycle, returning quotient or remainder of opA/opB.
//   clk_i   : clock
//   reset_i : asynchronous, active-high reset
//   io      : slave side of bsg_idiv_iterative_restoring_if (v/ready request,
//             v/yumi result)
// Optional build macro BSG_IDIV_ZERO_FAST_EN: a zero divisor seen at accept
// skips the calculation and the result is valid one edge after accept.
// Division by zero yields all-ones quotient and the original dividend as
// remainder in every build.
module bsg_idiv_iterative_restoring
    import bsg_idiv_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    bsg_idiv_iterative_restoring_if.slave    io
);
    localparam int                  cnt_w_lp    = idiv_cnt_width(width_p);
    localparam logic [cnt_w_lp-1:0] cnt_init_lp = cnt_w_lp'(width_p - 1);

    idiv_state_e         state_r;
    idiv_state_e         state_next_s;
    logic [width_p-1:0]  rem_r;
    logic [width_p-1:0]  dvd_r;     // dividend, shifts out as quotient shifts in
    logic [width_p-1:0]  dvs_r;
    logic [width_p-1:0]  result_r;
    logic                neg_a_r;
    logic                neg_b_r;
    logic                gets_rem_r;
    logic [cnt_w_lp-1:0] cnt_r;

    logic                accept_s;
    logic [width_p-1:0]  rem_next_s;
    logic                quot_bit_s;
    logic [width_p-1:0]  quot_adj_s;
    logic [width_p-1:0]  rem_adj_s;
`ifdef BSG_IDIV_ZERO_FAST_EN
    logic                opb_zero_s;
    assign opb_zero_s = (io.opB_i == '0);
`endif

    function automatic logic [width_p-1:0] negate(input logic [width_p-1:0] x);
        return (~x) + width_p'(1);
    endfunction

    // Magnitude is taken only for operands flagged signed with the MSB set.
    function automatic logic [width_p-1:0] abs_val(input logic [width_p-1:0] x,
                                                   input logic sgn);
        return (sgn & x[width_p-1]) ? negate(x) : x;
    endfunction

    assign accept_s = io.v_i & io.ready_o;

    bsg_idiv_restore_step #(.width_p(width_p)) step (
        .rem          (rem_r),
        .dividend_msb (dvd_r[width_p-1]),
        .divisor      (dvs_r),
        .rem_next     (rem_next_s),
        .quot_bit     (quot_bit_s)
    );

    // Sign fix-up. A zero divisor forces all-ones without negation; the
    // remainder path already reproduces the original dividend in that case.
    // min / -1 needs no special case: the magnitude quotient negates to min.
    assign quot_adj_s = (dvs_r == '0)         ? '1
                      : (neg_a_r ^ neg_b_r)  ? negate(dvd_r)
                      :                        dvd_r;
    assign rem_adj_s  = neg_a_r ? negate(rem_r) : rem_r;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            eIDLE: begin
                if (accept_s) begin
`ifdef BSG_IDIV_ZERO_FAST_EN
                    if (opb_zero_s) begin
                        state_next_s = eDONE;
                    end else begin
                        state_next_s = eCALC;
                    end
`else
                    state_next_s = eCALC;
`endif
                end else begin
                    state_next_s = eIDLE;
                end
            end
            eCALC: begin
                if (cnt_r == '0) begin
                    state_next_s = eADJ;
                end else begin
                    state_next_s = eCALC;
                end
            end
            eADJ:  state_next_s = eDONE;
            eDONE: begin
                if (io.yumi_i) begin
                    state_next_s = eIDLE;
                end else begin
                    state_next_s = eDONE;
                end
            end
            default: state_next_s = eIDLE;
        endcase
    end

    // Outputs decoded from the state register; the result comes from a register.
    always_comb begin
        io.ready_o  = (state_r == eIDLE);
        io.v_o      = (state_r == eDONE);
        io.result_o = result_r;
    end

    // Datapath: operand capture, restoring iterations and sign adjustment.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rem_r      <= '0;
            dvd_r      <= '0;
            dvs_r      <= '0;
            result_r   <= '0;
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            gets_rem_r <= 1'b0;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                eIDLE: begin
                    if (accept_s) begin
                        dvd_r      <= abs_val(io.opA_i, io.signed_opA_i);
                        dvs_r      <= abs_val(io.opB_i, io.signed_opB_i);
                        neg_a_r    <= io.signed_opA_i & io.opA_i[width_p-1];
                        neg_b_r    <= io.signed_opB_i & io.opB_i[width_p-1];
                        gets_rem_r <= io.gets_remainder_i;
                        rem_r      <= '0;
                        cnt_r      <= cnt_init_lp;
`ifdef BSG_IDIV_ZERO_FAST_EN
                        if (opb_zero_s) begin
                            result_r <= io.gets_remainder_i ? io.opA_i : '1;
                        end
`endif
                    end
                end
                eCALC: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[width_p-2:0], quot_bit_s};
                    cnt_r <= cnt_r - cnt_w_lp'(1);
                end
                eADJ: begin
                    result_r <= gets_rem_r ? rem_adj_s : quot_adj_s;
                end
                eDONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_idiv_iterative_restoring.sv
// Scoreboard bench for bsg_idiv_iterative_restoring (width 32). The driver
// issues requests and pushes the reference result; a monitor pops and compares
// whenever v_o is seen and returns yumi_i. The reference uses plain 64-bit
// signed arithmetic, which truncates toward zero like the M-extension.
module tb_bsg_idiv_iterative_restoring;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bsg_idiv_iterative_restoring_if #(.width_p(W)) dif ();

    bsg_idiv_iterative_restoring #(.width_p(W)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .io      (dif.slave)
    );

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [W-1:0]   exp_q[$];
    bit             hold = 1'b0;

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit sa, input bit sb, input bit gr);
        longint av, bv, q, r;
        av = sa ? longint'($signed(a)) : longint'(a);
        bv = sb ? longint'($signed(b)) : longint'(b);
        if (bv == 0) return gr ? a : {W{1'b1}};
        q = av / bv;
        r = av % bv;
        return gr ? r[W-1:0] : q[W-1:0];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each presented result, then consume it with yumi_i.
    initial begin
        dif.yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            if (dif.yumi_i) begin
                dif.yumi_i = 1'b0;
            end else if (dif.v_o === 1'b1 && !hold) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h want none", dif.result_o);
                end else begin
                    check("result", dif.result_o, exp_q.pop_front());
                end
                dif.yumi_i = 1'b1;
            end
        end
    end

    task automatic wait_ready();
        int i;
        i = 0;
        @(negedge clk);
        while (dif.ready_o !== 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (dif.ready_o !== 1'b1) check("ready_timeout", {31'd0, dif.ready_o}, 32'd1);
    endtask

    // Issue one request, push its expected result and measure latency.
    // Latency counts edges from the accept edge (inclusive) until v_o is high.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sa, input bit sb, input bit gr);
        int edges;
        int exp_lat;
        wait_ready();
        dif.opA_i = a;
        dif.opB_i = b;
        dif.signed_opA_i = sa;
        dif.signed_opB_i = sb;
        dif.gets_remainder_i = gr;
        dif.v_i = 1'b1;
        @(posedge clk);
        #1;
        dif.v_i = 1'b0;
        exp_q.push_back(ref_div(a, b, sa, sb, gr));
        check("ready_drop", {31'd0, dif.ready_o}, 32'd0);
        edges = 1;
        while (dif.v_o !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        exp_lat = W + 2;
`ifdef BSG_IDIV_ZERO_FAST_EN
        if (b == '0) exp_lat = 1;
`endif
        check("latency", W'(edges), W'(exp_lat));
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || dif.ready_o !== 1'b1) && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0) check("drain_timeout", W'(exp_q.size()), 32'd0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit sa, input bit sb, input bit gr);
        issue(a, b, sa, sb, gr);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] b;
        rst = 1'b1;
        dif.v_i = 1'b0;
        dif.opA_i = '0;
        dif.opB_i = '0;
        dif.signed_opA_i = 1'b0;
        dif.signed_opB_i = 1'b0;
        dif.gets_remainder_i = 1'b0;
        #12;
        check("reset_ready", {31'd0, dif.ready_o}, 32'd1);
        check("reset_v", {31'd0, dif.v_o}, 32'd0);
        check("reset_result", dif.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        op(32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
        op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0);
        op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b1);
        op(32'h0000_1234, 32'd0, 1'b1, 1'b1, 1'b0);
        op(32'h0000_1234, 32'd0, 1'b1, 1'b1, 1'b1);
        op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0);
        op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        op(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, 1'b1);
        op(32'hFFFF_FFF9, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);

        // Backpressure: result held, not ready, new requests ignored.
        hold = 1'b1;
        issue(32'd1000, 32'd33, 1'b0, 1'b0, 1'b0);
        held = dif.result_o;
        check("bp_first", held, ref_div(32'd1000, 32'd33, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dif.opA_i = $urandom;
            dif.opB_i = 32'd3;
            dif.v_i = 1'b1;
            check("bp_v", {31'd0, dif.v_o}, 32'd1);
            check("bp_result", dif.result_o, held);
            check("bp_ready", {31'd0, dif.ready_o}, 32'd0);
        end
        @(negedge clk);
        dif.v_i = 1'b0;
        hold = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("bp_no_extra", {31'd0, dif.v_o}, 32'd0);
        check("bp_idle", {31'd0, dif.ready_o}, 32'd1);

        // Reset in the fifth CALC cycle discards the operation asynchronously.
        wait_ready();
        dif.opA_i = 32'h1234_5678;
        dif.opB_i = 32'd3;
        dif.signed_opA_i = 1'b0;
        dif.signed_opB_i = 1'b0;
        dif.gets_remainder_i = 1'b0;
        dif.v_i = 1'b1;
        @(posedge clk);
        #1;
        dif.v_i = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_ready", {31'd0, dif.ready_o}, 32'd1);
        check("rst_mid_v", {31'd0, dif.v_o}, 32'd0);
        check("rst_mid_result", dif.result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 1'b0);

        // Randomized operations with a mix of divisor classes.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = '0;
                default: b = 32'd0 - $urandom_range(1, 20);
            endcase
            op(($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom, b,
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bsg_idiv_iterative_restoring.md
Name: bsg_idiv_iterative_restoring

Overview:
- Iterative restoring integer divider; the arithmetic inverse of the team's iterative multiplier.
- Uses the same v/ready in, v/yumi out handshake and the same operand, sign and part-select style as the multiplier.
- Resolves one quotient bit per cycle; returns either the quotient or the remainder of opA/opB.
- Sits beside the multiplier in the integer unit of the core pipeline (M-extension div/divu/rem/remu).

Parameters:
- width_p, 32, operand and result width in bits; legal range ≥ 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- v_i  in  1  request valid
- ready_o  out  1  divider idle and able to accept a request
- opA_i  in  width_p  dividend
- opB_i  in  width_p  divisor
- signed_opA_i  in  1  treat opA_i as two's complement
- signed_opB_i  in  1  treat opB_i as two's complement
- gets_remainder_i  in  1  1 = return remainder, 0 = return quotient
- v_o  out  1  result valid
- result_o  out  width_p  quotient or remainder
- yumi_i  in  1  consumer takes result; legal only while v_o=1

Behaviour:
- Clock and reset: single clock domain, clk_i. reset_i is asynchronous and active-high.
- Reset values: state=IDLE, ready_o=1, v_o=0, result_o=0, all datapath registers 0.
- States: IDLE → CALC → ADJ → DONE → IDLE.
- IDLE:
  - ready_o=1.
  - On v_i & ready_o at an edge: latch |opA|, |opB| (abs taken only when the matching signed bit is set and the MSB is 1), both negative flags, and gets_remainder_i.
  - Clear partial remainder; load counter=width_p-1; go to CALC.
  - ready_o drops the cycle after accept.
- CALC, one step per cycle:
  - Shift {rem,dividend} left 1 and form trial = rem - divisor on width_p+1 bits.
  - If trial is non-negative: rem=trial, quotient bit=1; otherwise keep rem, quotient bit=0.
  - Counter decrements; at 0 go to ADJ. CALC lasts exactly width_p cycles.
- ADJ, one cycle:
  - Quotient is negated if the dividend sign differs from the divisor sign.
  - Remainder is negated if the dividend was negative.
  - Select quotient or remainder into the result register; go to DONE.
- DONE:
  - v_o=1; result_o held stable.
  - On yumi_i, go to IDLE; ready_o=1 on the following cycle.
  - v_o stays asserted indefinitely without yumi_i.
- Latency: v_o first high width_p+2 edges after the accept edge. No back-to-back overlap (one op in flight).
- Divide by zero (opB=0):
  - Quotient = all ones in both signed and unsigned modes, forced in ADJ with no negation applied.
  - Remainder = original opA_i.
- Signed overflow (min / -1): quotient = min (0x8000_0000 for width_p=32), remainder = 0. This falls out of the unsigned core and must not be special-cased incorrectly.
- Mixed signedness is legal: each operand's signed bit applies independently.
- Reset mid-operation: outputs return to reset values immediately (async), and any in-flight result is discarded.
- Inputs other than v_i are don't-care outside the accept edge. yumi_i outside DONE is ignored.

Optional Feature:
- Macro: BSG_IDIV_ZERO_FAST_EN.
- Defined:
  - A divisor of 0 detected at accept bypasses CALC and ADJ.
  - The all-ones quotient or the opA_i remainder is loaded directly, and DONE is entered next edge, so v_o goes high 1 edge after accept.
- Undefined: division by zero takes the full width_p+2 latency with identical results.

Decomposition:
- Package bsg_idiv_pkg:
  - state enum {eIDLE, eCALC, eADJ, eDONE}
  - counter width function (`$clog2(width_p)`)
- Sub-module bsg_idiv_restore_step:
  - Combinational single restoring step.
  - Inputs: rem, dividend MSB, divisor. Outputs: next rem, quotient bit.
  - Parameterised by width_p.

Test Plan (width_p=32):
- Unsigned basics: unsigned 100/7 → quotient 14 (0x0000_000E); remainder 2. v_o exactly 34 edges after accept.
- Signed truncation: signed -7/2 (0xFFFF_FFF9/0x2) → quotient 0xFFFF_FFFD (-3); remainder 0xFFFF_FFFF (-1).
- Divide by zero: 0x0000_1234/0 in signed and unsigned modes → quotient 0xFFFF_FFFF, remainder 0x0000_1234. With BSG_IDIV_ZERO_FAST_EN, v_o 1 edge after accept.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0. Unsigned mode same operands → quotient 0, remainder 0x8000_0000.
- Backpressure: hold yumi_i=0 for 10 cycles in DONE → v_o stays 1, result_o stable, ready_o 0. A v_i asserted meanwhile is not accepted.
- Reset mid-CALC: assert reset_i at cycle 5 of CALC → ready_o=1, v_o=0 without a clock edge. Next request 0xFFFF_FFFF/0x10 unsigned → quotient 0x0FFF_FFFF.
